// File: rtl/fuzz_vector_player.sv
// fuzz_vector_player
//   Stores up to DEPTH stimulus vectors and plays them onto a DUT's flattened
//   input bus, one vector every HOLD cycles. CAP_LAT cycles after each launch
//   the DUT output is folded to SIG_W bits and compacted into a MISR, so one
//   signature word summarises a whole run.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   wr_en/addr/data   vector storage write port (honoured in IDLE/DONE only)
//   start             begin a run (honoured in IDLE/DONE only)
//   num_vec           vectors to play, clamped to DEPTH, sampled at start
//   exp_sig           expected signature, latched at start
//   dut_in            registered stimulus to the DUT
//   dut_out           DUT response
//   busy              run in progress (PLAY or DRAIN)
//   done              run complete, held until next start or rst
//   pass              sig matches latched exp_sig, valid while done
//   sig               current MISR value
//   vec_idx           index of the vector currently on dut_in
module fuzz_vector_player #(
  parameter int unsigned      IN_W    = 256,
  parameter int unsigned      OUT_W   = 319,
  parameter int unsigned      DEPTH   = 32,
  parameter int unsigned      HOLD    = 1,
  parameter int unsigned      CAP_LAT = 1,
  parameter int unsigned      SIG_W   = 32,
  parameter logic [SIG_W-1:0] POLY    = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED    = 32'hFFFFFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [IN_W-1:0]            wr_data,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_vec,
  input  logic [SIG_W-1:0]           exp_sig,
  output logic [IN_W-1:0]            dut_in,
  input  logic [OUT_W-1:0]           dut_out,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [SIG_W-1:0]           sig,
  output logic [$clog2(DEPTH)-1:0]   vec_idx
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned NW   = AW + 1;
  localparam int unsigned HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned NSL  = (OUT_W + SIG_W - 1) / SIG_W;
  localparam int unsigned PADW = NSL * SIG_W;

  typedef enum logic [1:0] {IDLE, PLAY, DRAIN, DONE} state_t;

  state_t               state, state_nxt;
  logic [IN_W-1:0]      mem [DEPTH];
  logic [NW-1:0]        n_lat;
  logic [NW-1:0]        n_start;
  logic [SIG_W-1:0]     exp_lat;
  logic [HW-1:0]        hold_cnt;
  logic [CAP_LAT-1:0]   cap_pipe;
  logic                 idle_like;
  logic                 accept;
  logic                 start_launch;
  logic                 play_launch;
  logic                 launch;
  logic                 last_vec;
  logic                 hold_end;
  logic                 cap;
  logic                 pipe_empty;

  // XOR of consecutive SIG_W-bit slices from bit 0; top slice zero-padded.
  function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] v);
    logic [PADW-1:0]  ext;
    logic [SIG_W-1:0] acc;
    ext = PADW'(v);
    acc = '0;
    for (int i = 0; i < int'(NSL); i++) acc ^= ext[i*SIG_W +: SIG_W];
    return acc;
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic [SIG_W-1:0] d);
    return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY : '0) ^ d;
  endfunction

  assign idle_like  = (state == IDLE) || (state == DONE);
  assign n_start    = (num_vec > NW'(DEPTH)) ? NW'(DEPTH) : num_vec;
  assign hold_end   = (hold_cnt == HW'(HOLD - 1));
  // vec_idx is the most recently launched vector, so this also means
  // "every vector of the run has been launched" while in PLAY.
  assign last_vec   = ({1'b0, vec_idx} == (n_lat - 1'b1));
  assign cap        = cap_pipe[CAP_LAT-1];
  assign pipe_empty = (cap_pipe == '0);
  assign launch     = start_launch | play_launch;

  assign busy = (state == PLAY) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = (state == DONE) && (sig == exp_lat);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    start_launch = 1'b0;
    play_launch  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept = 1'b1;
          if (n_start == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt    = PLAY;
            start_launch = 1'b1;
          end
        end
      end
      PLAY: begin
        // When the capture latency is shorter than the hold time the final
        // capture drains before the hold expires; finish straight from PLAY.
        if (last_vec && pipe_empty) begin
          state_nxt = DONE;
        end else if (hold_end) begin
          if (last_vec) state_nxt = DRAIN;
          else          play_launch = 1'b1;
        end
      end
      DRAIN: begin
        if (pipe_empty) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage is never cleared; writes are locked out during a run and reset.
  always_ff @(posedge clk) begin
    if (wr_en && idle_like && !rst) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      exp_lat <= exp_sig;
      n_lat   <= n_start;
    end
  end

  // Launch stage: drive dut_in and push a capture token.
  // Capture stage: token leaves the pipe CAP_LAT edges later, sample dut_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_in   <= '0;
      sig      <= SEED;
      vec_idx  <= '0;
      cap_pipe <= '0;
      hold_cnt <= '0;
    end else begin
      cap_pipe <= CAP_LAT'({cap_pipe, launch});
      if (accept)   sig <= SEED;
      else if (cap) sig <= misr_step(sig, fold(dut_out));
      if (start_launch) begin
        dut_in   <= mem[0];
        vec_idx  <= '0;
        hold_cnt <= '0;
      end else if (play_launch) begin
        dut_in   <= mem[vec_idx + 1'b1];
        vec_idx  <= vec_idx + 1'b1;
        hold_cnt <= '0;
      end else if ((state == PLAY) && !hold_end) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fuzz_vector_player.sv
// tb_fuzz_vector_player
//   Two player instances: A with default timing (HOLD=1, CAP_LAT=1) and
//   B with HOLD=3, CAP_LAT=2. Expected signatures come from a reference
//   model that folds each captured output bit-by-bit and advances the MISR
//   as multiplication by x modulo the feedback polynomial.
module tb_fuzz_vector_player;

  localparam logic [31:0]  POLY      = 32'h04C11DB7;
  localparam logic [31:0]  SEED      = 32'hFFFFFFFF;
  localparam logic [318:0] FLIP_MASK = 319'(1) << 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_wr_en, b_wr_en;
  logic [4:0]   wr_addr;
  logic [255:0] wr_data;
  logic         a_start, b_start;
  logic [5:0]   a_num, b_num;
  logic [31:0]  a_exp, b_exp;
  logic [255:0] a_dut_in, b_dut_in;
  logic [318:0] a_dut_out, b_dut_out;
  logic         a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [31:0]  a_sig, b_sig;
  logic [4:0]   a_idx, b_idx;
  logic         a_loop, a_flip, b_loop;

  assign a_dut_out = a_loop ? ({63'b0, a_dut_in} ^ ((a_flip && a_idx == 5'd7) ? FLIP_MASK : '0)) : '0;
  assign b_dut_out = b_loop ? {63'b0, b_dut_in} : '0;

  fuzz_vector_player u_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(a_start), .num_vec(a_num), .exp_sig(a_exp), .dut_in(a_dut_in),
    .dut_out(a_dut_out), .busy(a_busy), .done(a_done), .pass(a_pass),
    .sig(a_sig), .vec_idx(a_idx)
  );

  fuzz_vector_player #(.HOLD(3), .CAP_LAT(2)) u_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(b_start), .num_vec(b_num), .exp_sig(b_exp), .dut_in(b_dut_in),
    .dut_out(b_dut_out), .busy(b_busy), .done(b_done), .pass(b_pass),
    .sig(b_sig), .vec_idx(b_idx)
  );

  logic [255:0] vecs [32];
  int total = 0;
  int bad   = 0;

  task automatic chk1(input string tag, input logic o, input logic e);
    total++;
    assert (o === e) else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, o, e); end
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, o, e); end
  endtask

  task automatic chk256(input string tag, input logic [255:0] o, input logic [255:0] e);
    total++;
    assert (o === e) else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, o, e); end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model
  function automatic logic [31:0] mfold(input logic [318:0] o);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 319; j++) r[j % 32] = r[j % 32] ^ o[j];
    return r;
  endfunction

  function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] d);
    longint unsigned x;
    x = {32'b0, s} * 64'd2;
    if (x >= 64'h1_0000_0000) x = (x - 64'h1_0000_0000) ^ {32'b0, POLY};
    return x[31:0] ^ d;
  endfunction

  // Signature after n loopback captures; vector flipk has bit 300 inverted.
  function automatic logic [31:0] model_sig(input int n, input int flipk);
    logic [31:0]  s;
    logic [318:0] o;
    s = SEED;
    for (int k = 0; k < n; k++) begin
      o = {63'b0, vecs[k]};
      if (k == flipk) o[300] = ~o[300];
      s = mstep(s, mfold(o));
    end
    return s;
  endfunction

  task automatic chk_rst(input string p, input logic [255:0] di, input logic bz,
                         input logic dn, input logic ps, input logic [31:0] sg,
                         input logic [4:0] ix);
    chk256({p, "_din"}, di, '0);
    chk1({p, "_busy"}, bz, 1'b0);
    chk1({p, "_done"}, dn, 1'b0);
    chk1({p, "_pass"}, ps, 1'b0);
    chk32({p, "_sig"}, sg, SEED);
    chk32({p, "_idx"}, 32'(ix), 32'd0);
  endtask

  task automatic wr_both(input int addr, input logic [255:0] d);
    a_wr_en = 1'b1; b_wr_en = 1'b1; wr_addr = 5'(addr); wr_data = d;
    tick();
    a_wr_en = 1'b0; b_wr_en = 1'b0;
  endtask

  task automatic run_a(input int n, input logic [31:0] e, output int bc, output int mi);
    a_num = 6'(n); a_exp = e; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    bc = 0; mi = 0;
    for (int c = 0; c < 300 && !a_done; c++) begin
      if (a_busy) bc++;
      if (int'(a_idx) > mi) mi = int'(a_idx);
      tick();
    end
    chk1("a_run_finished", a_done, 1'b1);
  endtask

  task automatic run_b(input int n, input logic [31:0] e, input bit poke, output int bc);
    b_num = 6'(n); b_exp = e; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    bc = 0;
    for (int c = 0; c < 300 && !b_done; c++) begin
      if (b_busy) bc++;
      if (poke && c == 4) begin
        b_start = 1'b1; b_wr_en = 1'b1; wr_addr = 5'd2; wr_data = ~vecs[2];
      end
      tick();
      b_start = 1'b0; b_wr_en = 1'b0;
    end
    chk1("b_run_finished", b_done, 1'b1);
  endtask

  initial begin
    int bc, mi, ix, nc;
    logic [31:0]  g;
    logic [255:0] nv;

    rst = 1'b1; a_wr_en = 1'b0; b_wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    a_start = 1'b0; b_start = 1'b0; a_num = '0; b_num = '0; a_exp = '0; b_exp = '0;
    a_loop = 1'b0; a_flip = 1'b0; b_loop = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_rst("por_a", a_dut_in, a_busy, a_done, a_pass, a_sig, a_idx);
    chk_rst("por_b", b_dut_in, b_busy, b_done, b_pass, b_sig, b_idx);

    // Preload storage
    for (int k = 0; k < 32; k++)
      for (int w = 0; w < 8; w++) vecs[k][w*32 +: 32] = $urandom;
    vecs[0][255:240] = 16'hee3c;
    vecs[0][15:0]    = 16'h94b5;
    for (int k = 0; k < 32; k++) wr_both(k, vecs[k]);

    // Reset with noisy control inputs; storage must survive
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a_start = 1'($urandom); b_start = 1'($urandom);
      a_wr_en = 1'($urandom); b_wr_en = 1'($urandom);
      wr_addr = 5'd0; wr_data = ~vecs[0]; a_num = 6'd3; b_num = 6'd3;
      tick();
    end
    rst = 1'b0; a_start = 1'b0; b_start = 1'b0; a_wr_en = 1'b0; b_wr_en = 1'b0;
    chk_rst("rst_a", a_dut_in, a_busy, a_done, a_pass, a_sig, a_idx);
    chk_rst("rst_b", b_dut_in, b_busy, b_done, b_pass, b_sig, b_idx);

    // Single vector, dut_out tied low
    a_num = 6'd1; a_exp = 32'hFB3EE249; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk256("t2_din", a_dut_in, vecs[0]);
    chk1("t2_busy0", a_busy, 1'b1);
    chk1("t2_done0", a_done, 1'b0);
    chk32("t2_sig0", a_sig, SEED);
    tick();
    chk32("t2_sig1", a_sig, 32'hFB3EE249);
    chk32("t2_sig1_model", a_sig, mstep(SEED, 32'h0));
    chk1("t2_done1", a_done, 1'b0);
    tick();
    chk1("t2_done2", a_done, 1'b1);
    chk1("t2_pass2", a_pass, 1'b1);
    chk1("t2_busy2", a_busy, 1'b0);
    run_a(1, 32'h12345678, bc, mi);
    chk1("t2_badexp_pass", a_pass, 1'b0);
    chk32("t2_badexp_sig", a_sig, 32'hFB3EE249);

    // Write and start on the same edge: launch reads the old mem[0]
    for (int w = 0; w < 8; w++) nv[w*32 +: 32] = $urandom;
    a_wr_en = 1'b1; b_wr_en = 1'b1; wr_addr = 5'd0; wr_data = nv; a_num = 6'd1; a_start = 1'b1;
    tick();
    a_wr_en = 1'b0; b_wr_en = 1'b0; a_start = 1'b0;
    chk256("wrstart_old", a_dut_in, vecs[0]);
    vecs[0] = nv;
    tick(); tick();
    chk1("wrstart_done", a_done, 1'b1);
    run_a(1, SEED, bc, mi);
    chk256("wrstart_new", a_dut_in, nv);

    // Cycle-level timing on B: HOLD=3, CAP_LAT=2, 4 vectors
    b_loop = 1'b1;
    b_num = 6'd4; b_exp = model_sig(4, -1); b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      ix = (c / 3 > 3) ? 3 : c / 3;
      nc = (c < 2) ? 0 : (((c - 2) / 3 + 1 > 4) ? 4 : (c - 2) / 3 + 1);
      chk256($sformatf("t3_din_c%0d", c), b_dut_in, vecs[ix]);
      chk32($sformatf("t3_idx_c%0d", c), 32'(b_idx), ix);
      chk1($sformatf("t3_busy_c%0d", c), b_busy, c <= 11);
      chk1($sformatf("t3_done_c%0d", c), b_done, c >= 12);
      chk32($sformatf("t3_sig_c%0d", c), b_sig, model_sig(nc, -1));
      if (c < 13) tick();
    end
    chk1("t3_pass", b_pass, 1'b1);

    // Loopback checksum over 21 vectors, then one corrupted capture
    a_loop = 1'b1; a_flip = 1'b0;
    g = model_sig(21, -1);
    run_a(21, g, bc, mi);
    chk32("t4_sig", a_sig, g);
    chk1("t4_pass", a_pass, 1'b1);
    chk32("t4_busy_cycles", bc, 32'd22);
    chk32("t4_max_idx", mi, 32'd20);
    a_flip = 1'b1;
    run_a(21, g, bc, mi);
    chk1("t4_flip_pass", a_pass, 1'b0);
    chk32("t4_flip_sig", a_sig, model_sig(21, 7));
    a_flip = 1'b0;

    // Boundaries: zero vectors and over-range count
    run_a(0, SEED, bc, mi);
    chk32("t5_zero_sig", a_sig, SEED);
    chk1("t5_zero_pass", a_pass, 1'b1);
    chk32("t5_zero_busy", bc, 32'd0);
    chk256("t5_zero_din", a_dut_in, vecs[20]);
    run_a(0, 32'h0, bc, mi);
    chk1("t5_zero_pass_bad", a_pass, 1'b0);
    g = model_sig(32, -1);
    run_a(40, g, bc, mi);
    chk32("t5_clamp_sig", a_sig, g);
    chk1("t5_clamp_pass", a_pass, 1'b1);
    chk32("t5_clamp_busy", bc, 32'd33);
    chk32("t5_clamp_max_idx", mi, 32'd31);
    chk256("t5_clamp_din", a_dut_in, vecs[31]);

    // Protection: start/write pulses during PLAY are ignored
    g = model_sig(6, -1);
    run_b(6, g, 1'b1, bc);
    chk32("t6_poke_sig", b_sig, g);
    chk1("t6_poke_pass", b_pass, 1'b1);
    chk32("t6_poke_busy", bc, 32'd18);
    run_b(6, g, 1'b0, bc);
    chk32("t6_rerun_sig", b_sig, g);
    chk1("t6_rerun_pass", b_pass, 1'b1);

    // Reset right after the third launch, then a fresh run
    b_num = 6'd6; b_exp = g; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk256("t6_third_din", b_dut_in, vecs[2]);
    chk32("t6_third_idx", 32'(b_idx), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_rst("midrst_b", b_dut_in, b_busy, b_done, b_pass, b_sig, b_idx);
    chk_rst("midrst_a", a_dut_in, a_busy, a_done, a_pass, a_sig, a_idx);
    run_b(6, g, 1'b0, bc);
    chk32("t6_fresh_sig", b_sig, g);
    chk1("t6_fresh_pass", b_pass, 1'b1);
    chk32("t6_fresh_busy", bc, 32'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fuzz_vector_player.md
Name: fuzz_vector_player

Overview:
- Synthesizable stimulus/response engine for differential fuzz runs.
- Parametrised successor to the fixed-vector simulation benches: it stores up to DEPTH input vectors and plays them into a DUT's flattened input bus, one every HOLD cycles.
- It samples the DUT's flattened output CAP_LAT cycles after each launch and compacts the samples into a MISR signature, so multiple synthesis results can be compared by one word instead of a full per-cycle dump.
- Sits between the fuzz harness top and the generated top-under-test.

Parameters:
IN_W, 256, width of the flattened DUT input bus (concatenated DUT inputs, MSB first)
OUT_W, 319, width of the DUT output bus y
DEPTH, 32, number of vector storage entries
HOLD, 1, cycles each vector is held on dut_in (>=1)
CAP_LAT, 1, cycles from vector launch to the dut_out sample (>=1; may exceed HOLD)
SIG_W, 32, MISR width
POLY, 32'h04C11DB7, MISR feedback polynomial
SEED, 32'hFFFFFFFF, MISR initial value

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write vector storage
wr_addr  in  clog2(DEPTH)  storage write address
wr_data  in  IN_W  vector to store
start  in  1  begin a run (sampled in IDLE/DONE only)
num_vec  in  clog2(DEPTH)+1  vectors to play, sampled at start
exp_sig  in  SIG_W  expected signature, latched at start
dut_in  out  IN_W  registered stimulus to the DUT
dut_out  in  OUT_W  DUT response y
busy  out  1  run in progress (PLAY or DRAIN)
done  out  1  run complete, held until next start or rst
pass  out  1  sig == latched exp_sig; valid while done=1
sig  out  SIG_W  current MISR value
vec_idx  out  clog2(DEPTH)  index of the vector currently on dut_in

Behaviour:
- Reset (sync, priority over everything): state=IDLE, dut_in=0, busy=0, done=0, pass=0, sig=SEED, vec_idx=0, capture pipe cleared. Storage is NOT cleared. rst mid-run aborts immediately with the same values.
- States:
  - IDLE: accepts writes and start.
  - PLAY: launches vectors.
  - DRAIN: waits for outstanding captures.
  - DONE: holds results; accepts writes and start.
- wr_en is honoured only in IDLE/DONE and ignored in PLAY/DRAIN.
- wr_en and start on the same edge: the write completes, but the start-edge read of mem[0] returns the old content.
- start in IDLE/DONE:
  - N = min(num_vec, DEPTH).
  - Latch exp_sig, sig<=SEED, done<=0, pass<=0.
  - If N=0: go to DONE with pass=(SEED==exp_sig), done=1 on the next edge, and dut_in unchanged.
  - Otherwise: on the same edge, dut_in<=mem[0], vec_idx<=0, busy<=1, go to PLAY.
- start while busy is ignored.
- Launch timing (start edge = t): vector k is driven on dut_in at edge t+k*HOLD, for k=0..N-1. dut_in holds its last vector after the run.
- Capture: each launch pushes a token into a CAP_LAT-deep shift pipe. When a token exits at edge t+k*HOLD+CAP_LAT, sample dut_out and update sig as:
  sig <= (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ fold(dut_out)
- fold is the XOR of the ceil(OUT_W/SIG_W) consecutive SIG_W-bit slices of dut_out, starting at bit 0; the top slice is zero-padded.
- Exactly N captures occur per run.
- PLAY -> DRAIN at edge t+(N-1)*HOLD+HOLD.
- DRAIN -> DONE on the edge after the final capture, i.e. at edge t+(N-1)*HOLD+CAP_LAT+1. If CAP_LAT < HOLD, the transition is taken directly from PLAY at that edge.
- DONE: busy=0, done=1, pass=(sig==exp_sig latched), sig frozen. Stays in DONE until start or rst.
- Arithmetic is unsigned throughout. vec_idx never wraps within a run (max N-1).

Test Plan:
1. Reset: assert rst 2 cycles with random start/wr_en toggling -> dut_in=0, busy=0, done=0, pass=0, sig=FFFFFFFF; a follow-up run reproduces preloaded vectors, proving storage was not cleared.
2. Single vector, defaults: dut_out tied to 0, mem[0]=256'hee3c...94b5, num_vec=1, start at edge t -> dut_in=mem[0] at t, sig=32'hFB3EE249 at t+1, done=1 at t+2; pass=1 iff exp_sig=FB3EE249.
3. Timing, HOLD=3, CAP_LAT=2, num_vec=4: dut_in changes at edges t, t+3, t+6, t+9; captures at t+2, t+5, t+8, t+11; done at t+12; busy high from t through t+11.
4. Loopback checksum: dut_out=dut_in zero-extended, 21 known vectors -> sig equals the golden model value; flip one dut_out bit in vector 7 -> pass=0.
5. Boundaries: num_vec=0 -> done next edge, sig=SEED, pass=(exp_sig==FFFFFFFF); num_vec=40 with DEPTH=32 -> exactly 32 launches, vec_idx max 31.
6. Protection: start and wr_en pulsed during PLAY -> ignored (rerun yields an identical sig); rst at the third launch -> reset values next edge, then a fresh start completes normally.
